// File: rtl/lsu_data_mem.sv
// -----------------------------------------------------------------------------
// lsu_data_mem
//   Byte-addressed RV32 data memory for the MEM stage. Accepts one request at
//   a time over a valid/ready handshake and returns a single-cycle response
//   LAT cycles after the accept edge. Supports LB/LH/LW/LBU/LHU/SB/SH/SW with
//   byte-lane writes, sign/zero extension, and range/funct3/alignment errors.
//
//   Parameters
//     DEPTH   number of 32-bit words (power of two); byte space = 4*DEPTH
//     LAT     accept-to-response latency in cycles, legal 1..4
//     ADDR_W  width of req_addr
//
//   Ports
//     clk         rising-edge clock
//     reset       synchronous, active-high
//     req_valid   request present
//     req_ready   block can accept a request this cycle
//     req_we      1 = store, 0 = load
//     req_funct3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//     req_addr    byte address
//     req_wdata   store data (low byte/half/word used per funct3)
//     resp_valid  one-cycle response pulse
//     resp_rdata  extended load result; 0 for stores and errors
//     resp_err    access faulted, qualified by resp_valid
//
//   Build option
//     DMEM_MISALIGN_TRAP_EN  when defined, misaligned H/W accesses fault;
//                            otherwise the address is silently aligned.
// -----------------------------------------------------------------------------
module lsu_data_mem #(
   parameter int DEPTH  = 256,
   parameter int LAT    = 1,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err
);

   localparam int              IDX_W     = $clog2(DEPTH);
   localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(4 * DEPTH);
   localparam logic [1:0]      CNT_INIT  = 2'(LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q,   cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q,   err_d;

   logic [31:0] mem [DEPTH];

   // Request decode
   logic             accept;
   logic [1:0]       size;
   logic             is_unsigned;
   logic             f3_bad;
   logic             range_bad;
   logic             align_bad;
   logic             req_err;
   logic [1:0]       off;
   logic [IDX_W-1:0] word_idx;
   logic [31:0]      rd_word;
   logic [31:0]      rd_lane;
   logic [31:0]      load_val;
   logic [3:0]       be;
   logic [31:0]      wr_data;
   logic             wr_en;

   // NOTE: every signal written in an always_comb gets a default first, so no
   // path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      accept      = req_valid && (state_q == S_IDLE);
      size        = req_funct3[1:0];
      is_unsigned = req_funct3[2];

      // 011, 110, 111 are undefined; stores have no unsigned variants.
      f3_bad    = (size == 2'b11) || (is_unsigned && (size == 2'b10)) ||
                  (req_we && is_unsigned);
      range_bad = ({1'b0, req_addr} >= MEM_BYTES);

`ifdef DMEM_MISALIGN_TRAP_EN
      align_bad = ((size == 2'b01) && req_addr[0]) ||
                  ((size == 2'b10) && (req_addr[1:0] != 2'b00));
      off       = req_addr[1:0];
`else
      // Misaligned halves/words are silently rounded down to their boundary.
      align_bad = 1'b0;
      off       = req_addr[1:0];
      if (size == 2'b01) off[0] = 1'b0;
      if (size == 2'b10) off    = 2'b00;
`endif

      req_err  = f3_bad || range_bad || align_bad;
      word_idx = req_addr[IDX_W+1:2];
      rd_word  = range_bad ? 32'h0 : mem[word_idx];
      rd_lane  = rd_word >> {off, 3'b000};

      load_val = 32'h0;
      be       = 4'b0000;
      wr_data  = req_wdata;
      case (size)
         2'b00: begin
            load_val = is_unsigned ? {24'h0, rd_lane[7:0]}
                                   : {{24{rd_lane[7]}}, rd_lane[7:0]};
            be       = 4'b0001 << off;
            wr_data  = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            load_val = is_unsigned ? {16'h0, rd_lane[15:0]}
                                   : {{16{rd_lane[15]}}, rd_lane[15:0]};
            be       = off[1] ? 4'b1100 : 4'b0011;
            wr_data  = {2{req_wdata[15:0]}};
         end
         2'b10: begin
            load_val = rd_lane;
            be       = 4'b1111;
            wr_data  = req_wdata;
         end
         default: ;
      endcase

      // Reset on the accept edge must also cancel the write.
      wr_en = accept && req_we && !req_err && !reset;
   end

   // Handshake FSM: next state and outputs
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;

      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (accept) begin
               // Load data is sampled now and carried until the response.
               rdata_d = (req_we || req_err) ? 32'h0 : load_val;
               err_d   = req_err;
               cnt_d   = CNT_INIT;
               state_d = (LAT > 1) ? S_WAIT : S_RESP;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 2'd1;
            if (cnt_q == 2'd1) state_d = S_RESP;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      resp_rdata = (state_q == S_RESP) ? rdata_q : 32'h0;
      resp_err   = (state_q == S_RESP) && err_q;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of its inputs, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 2'd0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // NOTE: the storage array has no reset so it maps onto plain RAM; its
   // contents survive reset and are undefined until written.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_lsu_data_mem.sv
// -----------------------------------------------------------------------------
// tb_lsu_data_mem
//   Self-checking bench for lsu_data_mem. A LAT=1 instance runs a table of
//   directed load/store vectors; a LAT=3 instance runs hand-written sequences
//   for latency, busy-time request dropping and reset corner cases.
// -----------------------------------------------------------------------------
module tb_lsu_data_mem;

   localparam logic [2:0] F_B  = 3'b000;
   localparam logic [2:0] F_H  = 3'b001;
   localparam logic [2:0] F_W  = 3'b010;
   localparam logic [2:0] F_BU = 3'b100;
   localparam logic [2:0] F_HU = 3'b101;

`ifdef DMEM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   logic clk;

   // LAT = 1 instance
   logic        reset1, req_valid1, req_ready1, req_we1;
   logic [2:0]  req_funct3_1;
   logic [31:0] req_addr1, req_wdata1;
   logic        resp_valid1, resp_err1;
   logic [31:0] resp_rdata1;

   // LAT = 3 instance
   logic        reset3, req_valid3, req_ready3, req_we3;
   logic [2:0]  req_funct3_3;
   logic [31:0] req_addr3, req_wdata3;
   logic        resp_valid3, resp_err3;
   logic [31:0] resp_rdata3;

   int n_checks = 0;
   int n_pass   = 0;

   lsu_data_mem #(.DEPTH(256), .LAT(1), .ADDR_W(32)) dut1 (
      .clk        (clk),
      .reset      (reset1),
      .req_valid  (req_valid1),
      .req_ready  (req_ready1),
      .req_we     (req_we1),
      .req_funct3 (req_funct3_1),
      .req_addr   (req_addr1),
      .req_wdata  (req_wdata1),
      .resp_valid (resp_valid1),
      .resp_rdata (resp_rdata1),
      .resp_err   (resp_err1)
   );

   lsu_data_mem #(.DEPTH(256), .LAT(3), .ADDR_W(32)) dut3 (
      .clk        (clk),
      .reset      (reset3),
      .req_valid  (req_valid3),
      .req_ready  (req_ready3),
      .req_we     (req_we3),
      .req_funct3 (req_funct3_3),
      .req_addr   (req_addr3),
      .req_wdata  (req_wdata3),
      .resp_valid (resp_valid3),
      .resp_rdata (resp_rdata3),
      .resp_err   (resp_err3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h required %08h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata,
                               input logic exp_err);
      mk.we        = we;
      mk.f3        = f3;
      mk.addr      = addr;
      mk.wdata     = wdata;
      mk.exp_rdata = exp_rdata;
      mk.exp_err   = exp_err;
   endfunction

   // Wait (bounded) on a falling edge where the LAT=1 instance is ready.
   task automatic wait_ready1(input string name);
      int n = 0;
      @(negedge clk);
      while (!req_ready1 && n < 16) begin
         @(negedge clk);
         n++;
      end
      check({name, " ready"}, 32'(req_ready1), 32'd1);
   endtask

   task automatic wait_ready3(input string name);
      int n = 0;
      @(negedge clk);
      while (!req_ready3 && n < 16) begin
         @(negedge clk);
         n++;
      end
      check({name, " ready"}, 32'(req_ready3), 32'd1);
   endtask

   // Apply one vector to the LAT=1 instance; response must appear exactly
   // one cycle after the accept edge and last exactly one cycle.
   task automatic apply1(input int idx, input vec_t v);
      string nm;
      nm = $sformatf("v%0d", idx);
      wait_ready1(nm);
      req_valid1   = 1'b1;
      req_we1      = v.we;
      req_funct3_1 = v.f3;
      req_addr1    = v.addr;
      req_wdata1   = v.wdata;
      @(posedge clk);
      #1;
      req_valid1 = 1'b0;
      check({nm, " resp_valid"}, 32'(resp_valid1), 32'd1);
      check({nm, " rdata"}, resp_rdata1, v.exp_rdata);
      check({nm, " err"}, 32'(resp_err1), 32'(v.exp_err));
      @(posedge clk);
      #1;
      check({nm, " resp_pulse"}, 32'(resp_valid1), 32'd0);
   endtask

   // Issue one request to the LAT=3 instance and wait (bounded) for its response.
   task automatic run3(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat);
      wait_ready3(name);
      req_valid3   = 1'b1;
      req_we3      = we;
      req_funct3_3 = f3;
      req_addr3    = addr;
      req_wdata3   = wdata;
      @(posedge clk);
      #1;
      req_valid3 = 1'b0;
      lat = 1;
      while (!resp_valid3 && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!resp_valid3) lat = -1;
      rdata = resp_rdata3;
      err   = resp_err3;
   endtask

   vec_t vecs[$];

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      bit          seen;

      reset1 = 1'b1; req_valid1 = 1'b0; req_we1 = 1'b0; req_funct3_1 = F_W;
      req_addr1 = 32'h0; req_wdata1 = 32'h0;
      reset3 = 1'b1; req_valid3 = 1'b0; req_we3 = 1'b0; req_funct3_3 = F_W;
      req_addr3 = 32'h0; req_wdata3 = 32'h0;

      // Directed vectors for the LAT=1 instance (expected values hand-computed)
      vecs.push_back(mk(1, F_W,  32'h10,  32'hDEADBEEF, 32'h0, 0));
      vecs.push_back(mk(0, F_W,  32'h10,  32'h0, 32'hDEADBEEF, 0));
      vecs.push_back(mk(1, F_W,  32'h10,  32'h00000000, 32'h0, 0));
      vecs.push_back(mk(1, F_B,  32'h11,  32'h12345680, 32'h0, 0));
      vecs.push_back(mk(0, F_B,  32'h11,  32'h0, 32'hFFFFFF80, 0));
      vecs.push_back(mk(0, F_BU, 32'h11,  32'h0, 32'h00000080, 0));
      vecs.push_back(mk(0, F_W,  32'h10,  32'h0, 32'h00008000, 0));
      vecs.push_back(mk(0, F_H,  32'h10,  32'h0, 32'hFFFF8000, 0));
      vecs.push_back(mk(0, F_HU, 32'h10,  32'h0, 32'h00008000, 0));
      vecs.push_back(mk(1, F_W,  32'h0,   32'h55AA55AA, 32'h0, 0));
      vecs.push_back(mk(1, F_W,  32'h400, 32'h11223344, 32'h0, 1));
      vecs.push_back(mk(0, F_W,  32'h400, 32'h0, 32'h0, 1));
      vecs.push_back(mk(0, F_W,  32'h80000010, 32'h0, 32'h0, 1));
      vecs.push_back(mk(0, F_W,  32'h0,   32'h0, 32'h55AA55AA, 0));
      vecs.push_back(mk(1, F_W,  32'h3FC, 32'hCAFEF00D, 32'h0, 0));
      vecs.push_back(mk(0, F_W,  32'h3FC, 32'h0, 32'hCAFEF00D, 0));
      vecs.push_back(mk(0, F_BU, 32'h3FF, 32'h0, 32'h000000CA, 0));
      vecs.push_back(mk(0, F_B,  32'h3FE, 32'h0, 32'hFFFFFFFE, 0));
      vecs.push_back(mk(1, F_H,  32'h13,  32'h0000BEEF, 32'h0, TRAP));
      vecs.push_back(mk(0, F_W,  32'h10,  32'h0, TRAP ? 32'h00008000 : 32'hBEEF8000, 0));
      vecs.push_back(mk(0, F_B,  32'h13,  32'h0, TRAP ? 32'h00000000 : 32'hFFFFFFBE, 0));
      vecs.push_back(mk(0, F_W,  32'h12,  32'h0, TRAP ? 32'h00000000 : 32'hBEEF8000, TRAP));
      vecs.push_back(mk(0, F_H,  32'h12,  32'h0, TRAP ? 32'h00000000 : 32'hFFFFBEEF, 0));
      vecs.push_back(mk(0, 3'b011, 32'h10, 32'h0, 32'h0, 1));
      vecs.push_back(mk(0, 3'b110, 32'h10, 32'h0, 32'h0, 1));
      vecs.push_back(mk(1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, 1));
      vecs.push_back(mk(1, 3'b011, 32'h10, 32'hFFFFFFFF, 32'h0, 1));
      vecs.push_back(mk(0, F_W,  32'h10,  32'h0, TRAP ? 32'h00008000 : 32'hBEEF8000, 0));
      vecs.push_back(mk(1, F_H,  32'h2,   32'h00001234, 32'h0, 0));
      vecs.push_back(mk(0, F_W,  32'h0,   32'h0, 32'h123455AA, 0));
      vecs.push_back(mk(1, F_B,  32'h3FF, 32'h000000FF, 32'h0, 0));
      vecs.push_back(mk(0, F_W,  32'h3FC, 32'h0, 32'hFFFEF00D, 0));

      // Reset state, observed while reset is still held
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst1 req_ready",  32'(req_ready1),  32'd1);
      check("rst1 resp_valid", 32'(resp_valid1), 32'd0);
      check("rst1 resp_rdata", resp_rdata1,      32'h0);
      check("rst1 resp_err",   32'(resp_err1),   32'd0);
      check("rst3 req_ready",  32'(req_ready3),  32'd1);
      check("rst3 resp_valid", 32'(resp_valid3), 32'd0);
      @(negedge clk);
      reset1 = 1'b0;
      reset3 = 1'b0;

      foreach (vecs[i]) apply1(i, vecs[i]);

      // LAT=3: preload word 0, then LH with the exact ready/valid timeline
      run3("l3 sw", 1'b1, F_W, 32'h0, 32'h0000F00D, rd, er, lat);
      check("l3 sw latency", 32'(lat), 32'd3);
      check("l3 sw err", 32'(er), 32'd0);

      wait_ready3("l3 lh");
      req_valid3 = 1'b1; req_we3 = 1'b0; req_funct3_3 = F_H; req_addr3 = 32'h0;
      @(posedge clk);
      #1;
      // Hold a store request while busy; it must be ignored.
      req_we3 = 1'b1; req_funct3_3 = F_W; req_wdata3 = 32'hFFFFFFFF;
      check("l3 lh c1 ready", 32'(req_ready3),  32'd0);
      check("l3 lh c1 valid", 32'(resp_valid3), 32'd0);
      @(posedge clk);
      #1;
      check("l3 lh c2 ready", 32'(req_ready3),  32'd0);
      check("l3 lh c2 valid", 32'(resp_valid3), 32'd0);
      @(posedge clk);
      #1;
      req_valid3 = 1'b0;
      check("l3 lh c3 ready", 32'(req_ready3),  32'd0);
      check("l3 lh c3 valid", 32'(resp_valid3), 32'd1);
      check("l3 lh rdata",    resp_rdata3,      32'hFFFFF00D);
      check("l3 lh err",      32'(resp_err3),   32'd0);
      @(posedge clk);
      #1;
      check("l3 lh c4 ready", 32'(req_ready3),  32'd1);
      check("l3 lh c4 valid", 32'(resp_valid3), 32'd0);

      run3("l3 lw", 1'b0, F_W, 32'h0, 32'h0, rd, er, lat);
      check("l3 busy store ignored", rd, 32'h0000F00D);
      check("l3 lw latency", 32'(lat), 32'd3);

      // Reset the cycle after a load accept: response dropped
      wait_ready3("l3 rst mid");
      req_valid3 = 1'b1; req_we3 = 1'b0; req_funct3_3 = F_W; req_addr3 = 32'h0;
      @(posedge clk);
      #1;
      req_valid3 = 1'b0;
      reset3 = 1'b1;
      @(posedge clk);
      #1;
      reset3 = 1'b0;
      check("l3 rst mid ready", 32'(req_ready3), 32'd1);
      seen = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (resp_valid3) seen = 1'b1;
         @(posedge clk);
         #1;
      end
      check("l3 rst mid no resp", 32'(seen), 32'd0);

      // Reset on the accept edge suppresses the store
      wait_ready3("l3 rst acc");
      req_valid3 = 1'b1; req_we3 = 1'b1; req_funct3_3 = F_W;
      req_addr3 = 32'h0; req_wdata3 = 32'h12345678;
      reset3 = 1'b1;
      @(posedge clk);
      #1;
      req_valid3 = 1'b0;
      reset3 = 1'b0;
      check("l3 rst acc ready", 32'(req_ready3),  32'd1);
      check("l3 rst acc valid", 32'(resp_valid3), 32'd0);
      run3("l3 lw2", 1'b0, F_W, 32'h0, 32'h0, rd, er, lat);
      check("l3 rst acc no write", rd, 32'h0000F00D);
      check("l3 lw2 err", 32'(er), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
